// File: rtl/espi_cfg_pkg.sv
// Shared types and constants for the ESPI configuration sequencer.
package espi_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BRESP    = 2'b01;
    localparam logic [1:0] ERR_RRESP    = 2'b10;
    localparam logic [1:0] ERR_MISMATCH = 2'b11;
    localparam logic [1:0] RESP_OKAY    = 2'b00;

    function automatic logic state_is_busy(input state_e s);
        return (s == S_WR) || (s == S_WRESP) || (s == S_RADDR) || (s == S_RDATA);
    endfunction

endpackage

// File: rtl/espi_cfg_table.sv
// Configuration word table: one registered write port, asynchronous read by index.
// Latency: write visible on the read port the cycle after the strobe.
// Backpressure: none; out-of-range writes are dropped.
module espi_cfg_table #(
    parameter int NUM_WORDS = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_en_i,
    input  logic [3:0]  wr_idx_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  rd_idx_i,
    output logic [31:0] rd_data_o
);

    // Entries at or above NUM_WORDS are never written and stay at zero.
    logic [31:0] mem_q [16];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 16; k++) begin
                mem_q[k] <= '0;
            end
        end else if (wr_en_i && (32'(wr_idx_i) < 32'(NUM_WORDS))) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/espi_cfg_sequencer.sv
// AXI4-Lite master that writes the config table to the ESPI slave and verifies each word by readback.
// Latency: 4 cycles per word with a zero-wait slave; done rises 4*NUM_WORDS+1 cycles after start.
// Backpressure: every channel waits on its ready/valid indefinitely; AW and W complete independently.
module espi_cfg_sequencer
    import espi_cfg_pkg::*;
#(
    parameter int                              C_M00_AXI_ADDR_WIDTH = 32,
    parameter int                              C_M00_AXI_DATA_WIDTH = 32,
    parameter int                              NUM_WORDS            = 4,
    parameter logic [C_M00_AXI_ADDR_WIDTH-1:0] BASE_ADDR            = '0
) (
    input  logic                              m00_axi_aclk,
    input  logic                              m00_axi_aresetn,
    input  logic                              tbl_wr_en,
    input  logic [3:0]                        tbl_idx,
    input  logic [31:0]                       tbl_data,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [3:0]                        err_idx,
    output logic [1:0]                        err_code,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [2:0]                        m00_axi_awprot,
    output logic                              m00_axi_awvalid,
    input  logic                              m00_axi_awready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                              m00_axi_wvalid,
    input  logic                              m00_axi_wready,
    input  logic [1:0]                        m00_axi_bresp,
    input  logic                              m00_axi_bvalid,
    output logic                              m00_axi_bready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [2:0]                        m00_axi_arprot,
    output logic                              m00_axi_arvalid,
    input  logic                              m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]                        m00_axi_rresp,
    input  logic                              m00_axi_rvalid,
    output logic                              m00_axi_rready
);

    localparam int         AW       = C_M00_AXI_ADDR_WIDTH;
    localparam int         DW       = C_M00_AXI_DATA_WIDTH;
    localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

    state_e            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic              bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic [AW-1:0]     awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   wstrb_q, wstrb_d;
    logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [3:0]        err_idx_q, err_idx_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              start_acc, err_set;
    logic [1:0]        err_code_n;
    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic              tbl_we;
    logic [31:0]       tbl_rd, tbl_word;
    logic              enter_wr, stay_wr;

    assign tbl_we = tbl_wr_en && !busy_q;

    espi_cfg_table #(.NUM_WORDS(NUM_WORDS)) u_table (
        .clk_i     (m00_axi_aclk),
        .rst_ni    (m00_axi_aresetn),
        .wr_en_i   (tbl_we),
        .wr_idx_i  (tbl_idx),
        .wr_data_i (tbl_data),
        .rd_idx_i  (idx_d),
        .rd_data_o (tbl_rd)
    );

    // A table write landing on the same edge as start must reach word 0.
    assign tbl_word = (tbl_we && (tbl_idx == idx_d)) ? tbl_data : tbl_rd;

    assign aw_hs = awvalid_q && m00_axi_awready;
    assign w_hs  = wvalid_q  && m00_axi_wready;
    assign b_hs  = bready_q  && m00_axi_bvalid;
    assign ar_hs = arvalid_q && m00_axi_arready;
    assign r_hs  = rready_q  && m00_axi_rvalid;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        start_acc  = 1'b0;
        err_set    = 1'b0;
        err_code_n = ERR_NONE;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    start_acc = 1'b1;
                    idx_d     = '0;
                    state_d   = S_WR;
                end
            end
            S_WR: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_WRESP;
            end
            S_WRESP: begin
                if (b_hs) begin
                    if (m00_axi_bresp != RESP_OKAY) begin
                        state_d    = S_ERR;
                        err_set    = 1'b1;
                        err_code_n = ERR_BRESP;
                    end else begin
                        state_d = S_RADDR;
                    end
                end
            end
            S_RADDR: begin
                if (ar_hs) state_d = S_RDATA;
            end
            S_RDATA: begin
                if (r_hs) begin
                    if (m00_axi_rresp != RESP_OKAY) begin
                        state_d    = S_ERR;
                        err_set    = 1'b1;
                        err_code_n = ERR_RRESP;
                    end else if (m00_axi_rdata != wdata_q) begin
                        state_d    = S_ERR;
                        err_set    = 1'b1;
                        err_code_n = ERR_MISMATCH;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_WR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Every output is the registered image of what the next state needs.
    always_comb begin
        enter_wr   = (state_d == S_WR) && (state_q != S_WR);
        stay_wr    = (state_d == S_WR) && (state_q == S_WR);
        awvalid_d  = enter_wr || (stay_wr && awvalid_q && !m00_axi_awready);
        wvalid_d   = enter_wr || (stay_wr && wvalid_q && !m00_axi_wready);
        aw_done_d  = stay_wr && (aw_done_q || aw_hs);
        w_done_d   = stay_wr && (w_done_q || w_hs);
        awaddr_d   = enter_wr ? (BASE_ADDR + (AW'(idx_d) << 2)) : awaddr_q;
        araddr_d   = enter_wr ? (BASE_ADDR + (AW'(idx_d) << 2)) : araddr_q;
        wdata_d    = enter_wr ? tbl_word : wdata_q;
        wstrb_d    = enter_wr ? '1 : wstrb_q;
        bready_d   = (state_d == S_WRESP);
        arvalid_d  = (state_d == S_RADDR);
        rready_d   = (state_d == S_RDATA);
        busy_d     = state_is_busy(state_d);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
        err_idx_d  = err_idx_q;
        err_code_d = err_code_q;
        if (start_acc) begin
            err_idx_d  = '0;
            err_code_d = ERR_NONE;
        end else if (err_set) begin
            err_idx_d  = idx_q;
            err_code_d = err_code_n;
        end
    end

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_idx_q  <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            awaddr_q   <= awaddr_d;
            araddr_q   <= araddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_idx_q  <= err_idx_d;
            err_code_q <= err_code_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign err_idx         = err_idx_q;
    assign err_code        = err_code_q;
    assign m00_axi_awaddr  = awaddr_q;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_awvalid = awvalid_q;
    assign m00_axi_wdata   = wdata_q;
    assign m00_axi_wstrb   = wstrb_q;
    assign m00_axi_wvalid  = wvalid_q;
    assign m00_axi_bready  = bready_q;
    assign m00_axi_araddr  = araddr_q;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arvalid = arvalid_q;
    assign m00_axi_rready  = rready_q;

endmodule

// File: tb/tb_espi_cfg_sequencer.sv
// Directed bench for espi_cfg_sequencer with a configurable AXI4-Lite slave model.
module tb_espi_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        tbl_wr_en = 1'b0;
    logic [3:0]  tbl_idx = '0;
    logic [31:0] tbl_data = '0;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [3:0]  err_idx;
    logic [1:0]  err_code;

    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    espi_cfg_sequencer dut (
        .m00_axi_aclk    (clk),
        .m00_axi_aresetn (rstn),
        .tbl_wr_en       (tbl_wr_en),
        .tbl_idx         (tbl_idx),
        .tbl_data        (tbl_data),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .err_idx         (err_idx),
        .err_code        (err_code),
        .m00_axi_awaddr  (awaddr),
        .m00_axi_awprot  (awprot),
        .m00_axi_awvalid (awvalid),
        .m00_axi_awready (awready),
        .m00_axi_wdata   (wdata),
        .m00_axi_wstrb   (wstrb),
        .m00_axi_wvalid  (wvalid),
        .m00_axi_wready  (wready),
        .m00_axi_bresp   (bresp),
        .m00_axi_bvalid  (bvalid),
        .m00_axi_bready  (bready),
        .m00_axi_araddr  (araddr),
        .m00_axi_arprot  (arprot),
        .m00_axi_arvalid (arvalid),
        .m00_axi_arready (arready),
        .m00_axi_rdata   (rdata),
        .m00_axi_rresp   (rresp),
        .m00_axi_rvalid  (rvalid),
        .m00_axi_rready  (rready)
    );

    initial forever #5 clk = ~clk;

    // Slave model: memory of 16 registers, optional AW stall and error injection.
    int          aw_delay = 0;
    int          bad_b_word = -1;
    int          bad_r_word = -1;
    int          aw_wait, aw_cnt, w_cnt, b_cnt, ar_cnt;
    logic        aw_got, w_got;
    logic [31:0] aw_a, w_d;
    logic [31:0] smem   [16];
    logic [31:0] aw_log [16];
    logic [31:0] w_log  [16];
    logic [31:0] ar_log [16];

    assign awready = (aw_wait >= aw_delay);
    assign wready  = 1'b1;
    assign arready = 1'b1;
    assign rresp   = 2'b00;

    always @(posedge clk or negedge rstn) begin : slave
        logic        aw_h, w_h;
        logic [31:0] cur_a, cur_d;
        if (!rstn) begin
            aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rdata <= '0; aw_wait <= 0;
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0;
            aw_a <= '0; w_d <= '0;
            for (int k = 0; k < 16; k++) smem[k] <= '0;
        end else begin
            aw_h = awvalid && awready;
            w_h  = wvalid && wready;
            if (awvalid && !awready) aw_wait <= aw_wait + 1;
            else if (aw_h) aw_wait <= 0;
            if (aw_h) begin
                aw_got <= 1'b1; aw_a <= awaddr;
                aw_log[aw_cnt & 15] <= awaddr; aw_cnt <= aw_cnt + 1;
            end
            if (w_h) begin
                w_got <= 1'b1; w_d <= wdata;
                w_log[w_cnt & 15] <= wdata; w_cnt <= w_cnt + 1;
            end
            if ((aw_got || aw_h) && (w_got || w_h)) begin
                cur_a = aw_h ? awaddr : aw_a;
                cur_d = w_h ? wdata : w_d;
                smem[cur_a[5:2]] <= cur_d;
                bvalid <= 1'b1;
                bresp  <= (int'(cur_a[5:2]) == bad_b_word) ? 2'b10 : 2'b00;
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; b_cnt <= b_cnt + 1;
            end
            if (arvalid && arready) begin
                ar_log[ar_cnt & 15] <= araddr; ar_cnt <= ar_cnt + 1;
                rvalid <= 1'b1;
                rdata  <= (int'(araddr[5:2]) == bad_r_word) ? (smem[araddr[5:2]] ^ 32'h1)
                                                            : smem[araddr[5:2]];
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    logic [31:0] tv [4];
    int inj_at, aw_hi, w_hi, aw_bad;
    logic busy1;

    task automatic do_reset();
        rstn = 1'b0; start = 1'b0; tbl_wr_en = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_table();
        for (int k = 0; k < 4; k++) begin
            tbl_wr_en = 1'b1; tbl_idx = 4'(k); tbl_data = tv[k];
            @(negedge clk);
        end
        tbl_wr_en = 1'b0;
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_busy"}, busy, 0);
        check({p, "_done"}, done, 0);
        check({p, "_error"}, error, 0);
        check({p, "_err_idx"}, err_idx, 0);
        check({p, "_err_code"}, err_code, 0);
        check({p, "_awvalid"}, awvalid, 0);
        check({p, "_wvalid"}, wvalid, 0);
        check({p, "_bready"}, bready, 0);
        check({p, "_arvalid"}, arvalid, 0);
        check({p, "_rready"}, rready, 0);
        check({p, "_awaddr"}, awaddr, 0);
        check({p, "_araddr"}, araddr, 0);
        check({p, "_wdata"}, wdata, 0);
        check({p, "_wstrb"}, wstrb, 0);
    endtask

    // Pulses start (with an optional coincident table write) and runs to done/error.
    task automatic run_seq(input logic co_we, input logic [3:0] co_idx,
                           input logic [31:0] co_data, output int n);
        start = 1'b1; tbl_wr_en = co_we; tbl_idx = co_idx; tbl_data = co_data;
        n = 0; aw_hi = 0; w_hi = 0; aw_bad = 0; busy1 = 1'b0;
        do begin
            @(negedge clk);
            n++;
            start = 1'b0; tbl_wr_en = 1'b0;
            if (n == 1) busy1 = busy;
            if (n <= 6) begin
                if (awvalid) begin
                    aw_hi++;
                    if (awaddr != 32'h0) aw_bad++;
                end
                if (wvalid) w_hi++;
            end
            if (n == inj_at) begin
                start = 1'b1; tbl_wr_en = 1'b1; tbl_idx = 4'd1; tbl_data = 32'hFFFF_FFFF;
            end
        end while (!(done || error) && n < 400);
        check("seq_end", done | error, 1);
    endtask

    initial begin
        int n;
        tv[0] = 32'h0101_FFFF; tv[1] = 32'habcd_0001;
        tv[2] = 32'hdead_0011; tv[3] = 32'hbeef_0011;
        inj_at = 0;

        // Reset state while reset is held
        repeat (2) @(negedge clk);
        check_reset_vals("rst");

        // T1: zero-wait slave, full sequence
        do_reset(); load_table();
        run_seq(1'b0, 4'd0, 32'h0, n);
        check("t1_busy_after_start", busy1, 1);
        check("t1_done_cycle", n, 17);
        check("t1_done", done, 1);
        check("t1_error", error, 0);
        check("t1_busy_end", busy, 0);
        check("t1_aw_cnt", aw_cnt, 4);
        check("t1_ar_cnt", ar_cnt, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t1_awaddr%0d", k), aw_log[k], 32'(4 * k));
            check($sformatf("t1_wdata%0d", k), w_log[k], tv[k]);
            check($sformatf("t1_araddr%0d", k), ar_log[k], 32'(4 * k));
        end

        // T2: awready stalled 3 cycles, wready immediate
        do_reset(); load_table(); aw_delay = 3;
        run_seq(1'b0, 4'd0, 32'h0, n);
        check("t2_aw_high_cycles", aw_hi, 4);
        check("t2_w_high_cycles", w_hi, 1);
        check("t2_aw_addr_stable", aw_bad, 0);
        check("t2_done_cycle", n, 29);
        check("t2_done", done, 1);
        check("t2_b_cnt", b_cnt, 4);
        aw_delay = 0;

        // T3: BRESP error on word 2
        do_reset(); load_table(); bad_b_word = 2;
        run_seq(1'b0, 4'd0, 32'h0, n);
        check("t3_error", error, 1);
        check("t3_done", done, 0);
        check("t3_err_idx", err_idx, 2);
        check("t3_err_code", err_code, 2'b01);
        check("t3_busy", busy, 0);
        check("t3_ar_cnt", ar_cnt, 2);
        bad_b_word = -1;

        // T4: read data mismatch on word 2
        do_reset(); load_table(); bad_r_word = 2;
        run_seq(1'b0, 4'd0, 32'h0, n);
        check("t4_error", error, 1);
        check("t4_err_code", err_code, 2'b11);
        check("t4_err_idx", err_idx, 2);
        check("t4_busy", busy, 0);
        bad_r_word = -1;

        // T5: table write coincident with start lands; start/table write while busy are ignored
        do_reset(); load_table(); inj_at = 5;
        run_seq(1'b1, 4'd3, 32'h1234_5678, n);
        check("t5_done_cycle", n, 17);
        check("t5_done", done, 1);
        check("t5_w1", w_log[1], 32'habcd_0001);
        check("t5_w3", w_log[3], 32'h1234_5678);
        inj_at = 0;
        run_seq(1'b0, 4'd0, 32'h0, n);
        check("t5b_done_cycle", n, 17);
        check("t5b_w1", w_log[5], 32'habcd_0001);
        check("t5b_w3", w_log[7], 32'h1234_5678);

        // T6: asynchronous reset during word 1 RADDR
        do_reset(); load_table();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(arvalid && araddr == 32'h4) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_reached_raddr1", arvalid, 1);
        #2 rstn = 1'b0;
        #1 check_reset_vals("t6");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_seq(1'b0, 4'd0, 32'h0, n);
        check("t6_done", done, 1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t6_cleared_w%0d", k), w_log[k], 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
